spi_slave_rx: RTL
=================

Name: spi_slave_rx

Overview:
- SPI receiver (slave end) for the link driven by the team's SPI state machine master.
- Deserialises MSB-first frames on spi_data while spi_cs_l is low, sampling on spi_sclk rising edges.
- Presents each completed word on a valid/ready interface to downstream logic.
- All SPI inputs are oversampled in the system clk domain; spi_sclk is a data signal, never a clock.

Parameters:
- DATA_WIDTH, 16, bits per frame.
- SYNC_STAGES, 2, flops on each SPI input before edge detection (minimum 1).

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- spi_sclk  input  1  serial clock from master; idles low
- spi_cs_l  input  1  active-low chip select
- spi_data  input  1  serial data, MSB first
- rx_data  output  DATA_WIDTH  last completed word
- rx_valid  output  1  rx_data holds an unconsumed word
- rx_ready  input  1  downstream accepts rx_data
- bit_count  output  6  bits shifted in the current frame (0..DATA_WIDTH)
- busy  output  1  frame in progress (state RECV)
- frame_error  output  1  one-cycle pulse on a malformed frame
- overrun  output  1  one-cycle pulse when a completed word is dropped

Behaviour:
- Reset values: rx_data=0, rx_valid=0, bit_count=0, busy=0, frame_error=0, overrun=0.
  - Synchronizer flops reset to sclk=0, cs_l=1, data=0.
  - State resets to WAIT_IDLE.
- Synchronisation: spi_sclk, spi_cs_l and spi_data each pass through SYNC_STAGES flops, so they stay mutually aligned.
  - One extra register per line (sclk_d, cs_d) supports edge detection.
- Edge definitions:
  - Rising sclk edge: sclk_s=1 and sclk_d=0.
  - CS assert: cs_s=0 and cs_d=1.
  - CS deassert: cs_s=1 and cs_d=0.
- Input timing requirement: the master is synchronous to clk; each spi_sclk high and low phase is at least 1 clk cycle.
- State WAIT_IDLE: waits for cs_s=1, then goes to IDLE.
  - Prevents locking onto a frame already in progress at reset release.
- State IDLE: on CS assert, go to RECV with shift register=0 and bit_count=0.
- State RECV, on each rising sclk edge while cs_s=0:
  - If bit_count<DATA_WIDTH: shift = {shift[DATA_WIDTH-2:0], data_s}; bit_count += 1.
  - If bit_count==DATA_WIDTH: the bit is ignored, frame_error pulses, and the excess flag is set for this frame.
- Word completion: the edge that brings bit_count to DATA_WIDTH completes the word.
  - On the next cycle: if rx_valid=0 or rx_ready=1, the full word is loaded into rx_data and rx_valid=1.
  - Otherwise the word is dropped, overrun pulses, and rx_data is unchanged.
- Latency: rx_valid rises 1 cycle after the detected edge, i.e. SYNC_STAGES+2 clk cycles after the 16th spi_sclk rising edge at the pins.
- CS deassert in RECV: go to IDLE.
  - If 0<bit_count<DATA_WIDTH: frame_error pulses and the partial word is discarded.
  - bit_count returns to 0 one cycle later.
- Edge collision: a rising sclk edge in the same cycle as CS deassert is ignored, because cs_s=1.
- Handshake: rx_valid stays high until a cycle with rx_valid=1 and rx_ready=1, then clears next cycle.
  - If a new word is loaded in that same cycle, rx_valid stays 1 with the new data.
  - rx_data must not change while rx_valid=1 and rx_ready=0.
- Back-to-back frames: CS may reassert 1 clk after deassert; IDLE accepts it.
- Reset mid-frame: all state is cleared, no pulse is generated, and the block returns to WAIT_IDLE.
- busy=1 exactly while in RECV.
- frame_error and overrun never stay high for more than 1 cycle per event.
- Widths: bit_count saturates at DATA_WIDTH. The 6-bit port requires DATA_WIDTH≤63; this is checked by elaboration assertion.

Test Plan:
- Single frame 16'hFFF0 with sclk=clk/2, rx_ready=1 -> one rx_valid pulse, rx_data=16'hFFF0, bit_count peaks at 16, no error pulses.
- Three back-to-back frames 16'hFFF0, 16'h07D0, 16'h0BB8 with 1-cycle CS gaps -> rx_data sequence FFF0, 07D0, 0BB8, three valid handshakes.
- CS deasserted after 9 bits of 16'h07D0 -> frame_error pulses once, rx_valid stays 0, and the next full frame 16'h0BB8 is received correctly.
- 18 sclk edges in one frame of 16'h0BB8 -> rx_data=16'h0BB8 and 2 frame_error pulses.
- rx_ready=0 across two frames FFF0 then 07D0 -> rx_data holds FFF0 and overrun pulses once; after rx_ready=1, rx_valid clears.
- Reset asserted at bit 7 with cs_l held low -> outputs zero, the rest of that frame is ignored, and the next frame after cs_l high is received correctly.

Source files
------------

// File: rtl/spi_slave_rx_if.sv
// Bundle of SPI pins and the receive-side valid/ready word interface.
// The slave modport is the receiver's view; the master modport is the SPI master plus downstream consumer.
interface spi_slave_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  spi_sclk;
    logic                  spi_cs_l;
    logic                  spi_data;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [5:0]            bit_count;
    logic                  busy;
    logic                  frame_error;
    logic                  overrun;

    modport slave (
        input  spi_sclk, spi_cs_l, spi_data, rx_ready,
        output rx_data, rx_valid, bit_count, busy, frame_error, overrun
    );

    modport master (
        output spi_sclk, spi_cs_l, spi_data, rx_ready,
        input  rx_data, rx_valid, bit_count, busy, frame_error, overrun
    );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversamples sclk/cs_l/data in the clk domain, shifts MSB-first frames,
// and hands completed words to downstream logic over valid/ready.
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    spi_slave_rx_if.slave bus
);
    if (DATA_WIDTH > 63 || DATA_WIDTH < 2 || SYNC_STAGES < 1) begin : g_param_check
        $error("spi_slave_rx: DATA_WIDTH must be 2..63 and SYNC_STAGES at least 1");
    end

    localparam logic [5:0] DW6   = 6'(DATA_WIDTH);
    localparam logic [7:0] FLUSH = 8'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        RECV      = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   sclk_dly_q;
    logic                   cs_dly_q;

    logic sclk_s;
    logic cs_s;
    logic data_s;
    logic sclk_rise_s;
    logic cs_assert_s;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic [5:0]            bit_count_q;
    logic                  busy_q;
    logic                  frame_error_q;
    logic                  overrun_q;
    logic                  complete_q;
    logic [7:0]            flush_q;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign data_s      = data_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_dly_q;
    assign cs_assert_s = ~cs_s & cs_dly_q;

    // Equal-depth synchronizers keep the three SPI lines aligned to each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            data_sync_q <= {SYNC_STAGES{1'b0}};
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q[0] <= bus.spi_sclk;
            cs_sync_q[0]   <= bus.spi_cs_l;
            data_sync_q[0] <= bus.spi_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                cs_sync_q[i]   <= cs_sync_q[i-1];
                data_sync_q[i] <= data_sync_q[i-1];
            end
            sclk_dly_q <= sclk_s;
            cs_dly_q   <= cs_s;
        end
    end

    // Frame FSM, shift register and output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_IDLE;
            shift_q       <= {DATA_WIDTH{1'b0}};
            rx_data_q     <= {DATA_WIDTH{1'b0}};
            rx_valid_q    <= 1'b0;
            bit_count_q   <= 6'd0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            complete_q    <= 1'b0;
            flush_q       <= 8'd0;
        end else begin
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            complete_q    <= 1'b0;

            if (complete_q) begin
                if (!rx_valid_q || bus.rx_ready) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                // The synchronizers hold their reset value until refilled, so cs_s is
                // only trusted once real pin samples have propagated through them.
                WAIT_IDLE: begin
                    if (flush_q != FLUSH) begin
                        flush_q <= flush_q + 8'd1;
                    end else if (cs_s) begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (cs_assert_s) begin
                        state_q     <= RECV;
                        busy_q      <= 1'b1;
                        shift_q     <= {DATA_WIDTH{1'b0}};
                        bit_count_q <= 6'd0;
                    end
                end
                RECV: begin
                    if (cs_s) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        bit_count_q <= 6'd0;
                        if (bit_count_q != 6'd0 && bit_count_q < DW6) begin
                            frame_error_q <= 1'b1;
                        end
                    end else if (sclk_rise_s) begin
                        if (bit_count_q < DW6) begin
                            shift_q     <= {shift_q[DATA_WIDTH-2:0], data_s};
                            bit_count_q <= bit_count_q + 6'd1;
                            complete_q  <= (bit_count_q == DW6 - 6'd1);
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= WAIT_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.bit_count   = bit_count_q;
    assign bus.busy        = busy_q;
    assign bus.frame_error = frame_error_q;
    assign bus.overrun     = overrun_q;
endmodule
